alu_74382_seq_ctrl: RTL and testbench

ALU_74382_SEQ_CTRL -- requirements
Module: alu_74382_seq_ctrl

---
 rtl/alu_74382_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_74382_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_74382_seq_ctrl.sv
// Sequencer that chains one 4-bit 74382 ALU slice over CHAIN_W/SLICE_W steps, LSB nibble first.
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds the rsp_zero output.
module alu_74382_seq_ctrl #(
  parameter int CHAIN_W  = 16,
  parameter int SLICE_W  = 4,
  parameter int SELECT_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the offering side holds its payload stable until that edge.
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SELECT_W-1:0] req_sel,
  input  logic [CHAIN_W-1:0]  req_a,
  input  logic [CHAIN_W-1:0]  req_b,
  input  logic                req_cn,
  output logic [SELECT_W-1:0] slice_sel,
  output logic [SLICE_W-1:0]  slice_a,
  output logic [SLICE_W-1:0]  slice_b,
  output logic                slice_cn,
  input  logic [SLICE_W-1:0]  slice_f,
  input  logic                slice_ovr,
  input  logic                slice_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [CHAIN_W-1:0]  rsp_result,
  output logic                rsp_ovr,
  output logic                rsp_cout,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic                rsp_zero,
`endif
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam int N     = CHAIN_W / SLICE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [SELECT_W-1:0] sel_q;
  logic [CHAIN_W-1:0]  a_q;
  logic [CHAIN_W-1:0]  b_q;
  logic                cn_q;
  logic [CNT_W-1:0]    cnt;
  logic [CHAIN_W-1:0]  result;
  logic                cout_q;
  logic                ovr_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    rsp_valid  = 1'b0;
    slice_sel  = '0;
    slice_a    = '0;
    slice_b    = '0;
    slice_cn   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) next_state = RUN;
      end
      RUN: begin
        slice_sel = sel_q;
        slice_a   = a_q[cnt*SLICE_W +: SLICE_W];
        slice_b   = b_q[cnt*SLICE_W +: SLICE_W];
        // Carry ripples through the register between steps.
        slice_cn  = (cnt == '0) ? cn_q : cout_q;
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cn_q   <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sel_q  <= req_sel;
            a_q    <= req_a;
            b_q    <= req_b;
            cn_q   <= req_cn;
            cnt    <= '0;
            result <= '0;
          end
        end
        RUN: begin
          result[cnt*SLICE_W +: SLICE_W] <= slice_f;
          cout_q <= slice_cout;
          ovr_q  <= slice_ovr;
          // Counter parks on the last step instead of wrapping.
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_result = result;
  assign rsp_cout   = cout_q;
  assign rsp_ovr    = ovr_q;
  assign state_dbg  = state;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zero = (state == DONE) && (result == '0);
`endif

endmodule

// File: tb/tb_alu_74382_seq_ctrl.sv
// Bench for alu_74382_seq_ctrl: behavioural 74382 slice plus a whole-word reference model.
module tb_alu_74382_seq_ctrl;
  localparam int CW = 16;
  localparam int SW = 4;
  localparam int N  = CW / SW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_sel = '0;
  logic [CW-1:0] req_a = '0;
  logic [CW-1:0] req_b = '0;
  logic          req_cn = 1'b0;
  logic [2:0]    slice_sel;
  logic [SW-1:0] slice_a, slice_b, slice_f;
  logic          slice_cn, slice_ovr, slice_cout;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [CW-1:0] rsp_result;
  logic          rsp_ovr, rsp_cout, busy;
  logic [1:0]    state_dbg;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic          rsp_zero;
`endif

  alu_74382_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_a(req_a), .req_b(req_b), .req_cn(req_cn),
    .slice_sel(slice_sel), .slice_a(slice_a), .slice_b(slice_b), .slice_cn(slice_cn),
    .slice_f(slice_f), .slice_ovr(slice_ovr), .slice_cout(slice_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_ovr(rsp_ovr), .rsp_cout(rsp_cout),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .rsp_zero(rsp_zero),
`endif
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 74382 slice model ----------------
  function automatic logic [5:0] slice_model(input logic [2:0] s, input logic [3:0] a,
                                             input logic [3:0] b, input logic cn);
    logic [3:0] x, y, f;
    logic [4:0] sum;
    logic       c, v;
    x = a; y = b; f = '0; c = 1'b0; v = 1'b0;
    case (s)
      3'd0: f = 4'h0;
      3'd1, 3'd2, 3'd3: begin
        if (s == 3'd1) begin x = b; y = ~a; end
        else if (s == 3'd2) begin x = a; y = ~b; end
        sum = {1'b0, x} + {1'b0, y} + {4'b0, cn};
        f = sum[3:0];
        c = sum[4];
        v = (x[3] == y[3]) && (f[3] != x[3]);
      end
      3'd4: f = a ^ b;
      3'd5: f = a | b;
      3'd6: f = a & b;
      default: f = 4'hF;
    endcase
    return {v, c, f};
  endfunction

  always_comb {slice_ovr, slice_cout, slice_f} = slice_model(slice_sel, slice_a, slice_b, slice_cn);

  // ---------------- whole-word reference model: {ovr, cout, result} ----------------
  function automatic logic [CW+1:0] ref_op(input logic [2:0] s, input logic [CW-1:0] a,
                                           input logic [CW-1:0] b, input logic cn);
    logic [CW-1:0] x, y, r;
    logic [CW:0]   sum;
    logic          c, v;
    x = a; y = b; r = '0; c = 1'b0; v = 1'b0;
    case (s)
      3'd0: r = '0;
      3'd1, 3'd2, 3'd3: begin
        if (s == 3'd1) begin x = b; y = ~a; end
        else if (s == 3'd2) begin x = a; y = ~b; end
        sum = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, cn};
        r = sum[CW-1:0];
        c = sum[CW];
        v = (x[CW-1] == y[CW-1]) && (r[CW-1] != x[CW-1]);
      end
      3'd4: r = a ^ b;
      3'd5: r = a | b;
      3'd6: r = a & b;
      default: r = '1;
    endcase
    return {v, c, r};
  endfunction

  // ---------------- scoreboard ----------------
  logic [CW+1:0] exp_q[$];
  int            due_q[$];
  int            total = 0;
  int            bad = 0;
  int            run_start = 0;
  logic [2:0]    cur_sel = '0;
  logic [CW-1:0] cur_a = '0, cur_b = '0;
  logic          cur_cn = 1'b0;
  logic          prev_valid = 1'b0;
  logic [CW+1:0] exp_v;
  int            step_n;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else if (rsp_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp: got result=%h with no operation pending", rsp_result);
      end else begin
        exp_v = exp_q[0];
        if ({rsp_ovr, rsp_cout, rsp_result} !== exp_v) begin
          bad++;
          $display("FAIL rsp: got ovr=%b cout=%b result=%h, want ovr=%b cout=%b result=%h",
                   rsp_ovr, rsp_cout, rsp_result, exp_v[CW+1], exp_v[CW], exp_v[CW-1:0]);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        total++;
        if (rsp_zero !== (exp_v[CW-1:0] == '0)) begin
          bad++;
          $display("FAIL rsp_zero: got %b want %b", rsp_zero, exp_v[CW-1:0] == '0);
        end
`endif
        if (!prev_valid) begin
          total++;
          if (cyc != due_q[0]) begin
            bad++;
            $display("FAIL latency: rsp_valid at cycle %0d, want %0d", cyc, due_q[0]);
          end
        end
      end
      prev_valid = 1'b1;
    end else begin
      if (prev_valid && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      prev_valid = 1'b0;
      total++;
      if (busy) begin
        step_n = cyc - run_start - 1;
        if (slice_sel !== cur_sel || slice_a !== 4'(cur_a >> (SW*step_n)) ||
            slice_b !== 4'(cur_b >> (SW*step_n)) || (step_n == 0 && slice_cn !== cur_cn)) begin
          bad++;
          $display("FAIL slice_drive step %0d: got sel=%0d a=%h b=%h cn=%b, want sel=%0d a=%h b=%h",
                   step_n, slice_sel, slice_a, slice_b, slice_cn, cur_sel,
                   4'(cur_a >> (SW*step_n)), 4'(cur_b >> (SW*step_n)));
        end
      end else if ({slice_sel, slice_a, slice_b, slice_cn} !== '0) begin
        bad++;
        $display("FAIL slice_idle: got sel=%0d a=%h b=%h cn=%b, want all 0",
                 slice_sel, slice_a, slice_b, slice_cn);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input logic [2:0] s, input logic [CW-1:0] a, input logic [CW-1:0] b,
                       input logic cn);
    int waited;
    req_sel = s; req_a = a; req_b = b; req_cn = cn; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles, want 1", waited);
    end else begin
      run_start = cyc;
      cur_sel = s; cur_a = a; cur_b = b; cur_cn = cn;
      exp_q.push_back(ref_op(s, a, b, cn));
      due_q.push_back(cyc + N + 1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_a = CW'($urandom);
    req_b = CW'($urandom);
  endtask

  task automatic finish(input int hold, input bit probe, output logic [CW-1:0] r,
                        output logic co, output logic ov);
    int waited;
    waited = 0;
    while (!rsp_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, want 1", waited);
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      req_valid = probe && (i == 1);
      if (probe) begin
        req_sel = 3'd3; req_a = 16'h1111; req_b = 16'h2222;
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
    r = rsp_result; co = rsp_cout; ov = rsp_ovr;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (probe) check("probe_not_accepted", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] s, input logic [CW-1:0] a, input logic [CW-1:0] b,
                        input logic cn, input int hold, input bit probe,
                        output logic [CW-1:0] r, output logic co, output logic ov);
    issue(s, a, b, cn);
    finish(hold, probe, r, co, ov);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_rsp"}, {14'b0, rsp_valid, rsp_ovr, rsp_cout, rsp_result}, 32'd0);
    check({tag, "_slice"}, {20'b0, slice_sel, slice_a, slice_b, slice_cn}, 32'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check({tag, "_zero"}, {31'b0, rsp_zero}, 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [CW-1:0] r;
  logic          co, ov;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd3, 16'h00FF, 16'h0001, 1'b0, 0, 1'b0, r, co, ov);
    check("add_carry_result", {16'b0, r}, 32'h0100);
    check("add_carry_cout", {31'b0, co}, 32'd0);

    run_op(3'd3, 16'hFFFF, 16'h0001, 1'b0, 1, 1'b0, r, co, ov);
    check("add_wrap_result", {16'b0, r}, 32'h0000);
    check("add_wrap_cout", {31'b0, co}, 32'd1);

    run_op(3'd2, 16'h1234, 16'h0234, 1'b1, 0, 1'b0, r, co, ov);
    check("sub_result", {16'b0, r}, 32'h1000);
    check("sub_cout", {31'b0, co}, 32'd1);

    run_op(3'd3, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, r, co, ov);
    check("add_ovr_result", {16'b0, r}, 32'h8000);
    check("add_ovr_flag", {31'b0, ov}, 32'd1);

    // Back-pressure window with a stray request pulse inside it.
    run_op(3'd1, 16'h0010, 16'h0030, 1'b1, 5, 1'b1, r, co, ov);
    check("bp_b_minus_a", {16'b0, r}, 32'h0020);

    // Abort in RUN step 2.
    issue(3'd3, 16'hABCD, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_op(3'd3, 16'h0F0F, 16'h0101, 1'b1, 0, 1'b0, r, co, ov);
    check("post_abort_result", {16'b0, r}, 32'h1011);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), CW'($urandom), CW'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'b0, r, co, ov);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
